// File: rtl/id_ex_pkg.sv
// Shared types for the ID->EX pipeline stage: default widths, payload layout,
// skid-buffer state encoding and the all-zero bubble payload.
package id_ex_pkg;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_ALU_SEL_W  = 3;
  localparam int unsigned DEF_ALU_OP_W   = 8;
  localparam int unsigned DEF_REG_ADDR_W = 5;

  // Field order matches the packing used by id_ex_stage (sel is the MSB end)
  typedef struct packed {
    logic [DEF_ALU_SEL_W-1:0]  sel;
    logic [DEF_ALU_OP_W-1:0]   op;
    logic [DEF_DATA_W-1:0]     op1;
    logic [DEF_DATA_W-1:0]     op2;
    logic                      we;
    logic [DEF_REG_ADDR_W-1:0] waddr;
  } id_ex_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } skid_state_e;

  localparam id_ex_payload_t PAYLOAD_ZERO = '0;

endpackage

// File: rtl/id_ex_skid_buf.sv
// Generic valid/ready register slice with synchronous flush.
// ID_EX_SKID_EN defined: 2-entry (main + skid) buffer with a registered in_ready.
// ID_EX_SKID_EN undefined: single register, in_ready = !out_valid | out_ready.
module id_ex_skid_buf
  import id_ex_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

`ifdef ID_EX_SKID_EN
  localparam logic [1:0] ST_EMPTY = 2'(EMPTY);
  localparam logic [1:0] ST_FULL  = 2'(FULL);
  localparam logic [1:0] ST_SKID  = 2'(SKID);

  logic [1:0]   state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         valid_q;
  logic         ready_q;
  logic         acc;
  logic         del;

  assign acc       = in_valid & ready_q;
  assign del       = valid_q & out_ready;
  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = main_q;

  // Next-state and next-data for the main/skid pair
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d = ST_FULL;
            main_d  = in_data;
          end
        end
        ST_FULL: begin
          if (acc && del) begin
            main_d = in_data;
          end else if (acc) begin
            state_d = ST_SKID;
            skid_d  = in_data;
          end else if (del) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (del) begin
            state_d = ST_FULL;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State, data and registered handshake flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= (state_d != ST_EMPTY);
      ready_q <= (state_d != ST_SKID);
    end
  end
`else
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         acc;

  assign in_ready  = ~valid_q | out_ready;
  assign acc       = in_valid & in_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Next value of the single holding register
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (acc) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: valid/ready slice carrying the ALU/operand/writeback
// payload, bubble-safe write enable and a saturating EX stall counter.
// Build option: ID_EX_SKID_EN selects the 2-entry skid buffer with registered id_ready_o.
module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ALU_SEL_W  = DEF_ALU_SEL_W,
  parameter int unsigned ALU_OP_W   = DEF_ALU_OP_W,
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  id_valid_i,
  output logic                  id_ready_o,
  input  logic [ALU_SEL_W-1:0]  id_alu_sel_i,
  input  logic [ALU_OP_W-1:0]   id_alu_op_i,
  input  logic [DATA_W-1:0]     id_op_number_1_i,
  input  logic [DATA_W-1:0]     id_op_number_2_i,
  input  logic                  id_write_reg_en_i,
  input  logic [REG_ADDR_W-1:0] id_write_reg_addr_i,
  output logic                  ex_valid_o,
  input  logic                  ex_ready_i,
  output logic [ALU_SEL_W-1:0]  ex_alu_sel_o,
  output logic [ALU_OP_W-1:0]   ex_alu_op_o,
  output logic [DATA_W-1:0]     ex_op_number_1_o,
  output logic [DATA_W-1:0]     ex_op_number_2_o,
  output logic                  ex_write_reg_en_o,
  output logic [REG_ADDR_W-1:0] ex_write_reg_addr_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  localparam int unsigned PAYLOAD_W = ALU_SEL_W + ALU_OP_W + 2 * DATA_W + 1 + REG_ADDR_W;

  logic [PAYLOAD_W-1:0] pl_in;
  logic [PAYLOAD_W-1:0] pl_out;
  logic                 we_raw;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  assign pl_in = {id_alu_sel_i, id_alu_op_i, id_op_number_1_i, id_op_number_2_i,
                  id_write_reg_en_i, id_write_reg_addr_i};

  id_ex_skid_buf #(
    .W (PAYLOAD_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush_i),
    .in_valid  (id_valid_i),
    .in_ready  (id_ready_o),
    .in_data   (pl_in),
    .out_valid (ex_valid_o),
    .out_ready (ex_ready_i),
    .out_data  (pl_out)
  );

  assign {ex_alu_sel_o, ex_alu_op_o, ex_op_number_1_o, ex_op_number_2_o,
          we_raw, ex_write_reg_addr_o} = pl_out;

  // Bubbles never write back
  assign ex_write_reg_en_o = ex_valid_o & we_raw;

  // Saturating count of cycles where EX back-pressures a valid beat
  always_comb begin
    cnt_d = cnt_q;
    if (ex_valid_o && !ex_ready_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Stall counter register; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomised self-checking bench for id_ex_stage against a queue-based reference model.
// Works for both builds (ID_EX_SKID_EN defined or not).
module tb_id_ex_stage;
  import id_ex_pkg::*;

  localparam int unsigned CW      = 4;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;
`ifdef ID_EX_SKID_EN
  localparam int unsigned CAP = 2;
`else
  localparam int unsigned CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush_i = 1'b0;
  logic        id_valid_i = 1'b0;
  logic        id_ready_o;
  logic [2:0]  id_alu_sel_i = '0;
  logic [7:0]  id_alu_op_i = '0;
  logic [31:0] id_op_number_1_i = '0;
  logic [31:0] id_op_number_2_i = '0;
  logic        id_write_reg_en_i = 1'b0;
  logic [4:0]  id_write_reg_addr_i = '0;
  logic        ex_valid_o;
  logic        ex_ready_i = 1'b0;
  logic [2:0]  ex_alu_sel_o;
  logic [7:0]  ex_alu_op_o;
  logic [31:0] ex_op_number_1_o;
  logic [31:0] ex_op_number_2_o;
  logic        ex_write_reg_en_o;
  logic [4:0]  ex_write_reg_addr_o;
  logic [CW-1:0] stall_cnt_o;

  id_ex_stage #(.CNT_W(CW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .flush_i             (flush_i),
    .id_valid_i          (id_valid_i),
    .id_ready_o          (id_ready_o),
    .id_alu_sel_i        (id_alu_sel_i),
    .id_alu_op_i         (id_alu_op_i),
    .id_op_number_1_i    (id_op_number_1_i),
    .id_op_number_2_i    (id_op_number_2_i),
    .id_write_reg_en_i   (id_write_reg_en_i),
    .id_write_reg_addr_i (id_write_reg_addr_i),
    .ex_valid_o          (ex_valid_o),
    .ex_ready_i          (ex_ready_i),
    .ex_alu_sel_o        (ex_alu_sel_o),
    .ex_alu_op_o         (ex_alu_op_o),
    .ex_op_number_1_o    (ex_op_number_1_o),
    .ex_op_number_2_o    (ex_op_number_2_o),
    .ex_write_reg_en_o   (ex_write_reg_en_o),
    .ex_write_reg_addr_o (ex_write_reg_addr_o),
    .stall_cnt_o         (stall_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model: beats currently held by the stage, oldest first
  id_ex_payload_t held[$];
  int unsigned    m_cnt = 0;
  bit             m_zero = 1'b1;
  bit             watch_dead = 1'b0;
  bit             seen_dead = 1'b0;
  int unsigned    n_checks = 0;
  int unsigned    n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // The stage takes a beat while it has room; the 1-entry build may also reuse
  // the slot being delivered this cycle
  function automatic bit m_ready();
    if (CAP == 2) return held.size() < 2;
    return (held.size() == 0) || (ex_ready_i == 1'b1);
  endfunction

  function automatic id_ex_payload_t rand_beat();
    id_ex_payload_t p;
    p.sel   = 3'($urandom);
    p.op    = 8'($urandom);
    p.op1   = $urandom;
    p.op2   = $urandom;
    p.we    = 1'($urandom);
    p.waddr = 5'($urandom);
    return p;
  endfunction

  task automatic drive(input bit v, input bit r, input bit fl, input id_ex_payload_t p);
    id_valid_i          = v;
    ex_ready_i          = r;
    flush_i             = fl;
    id_alu_sel_i        = p.sel;
    id_alu_op_i         = p.op;
    id_op_number_1_i    = p.op1;
    id_op_number_2_i    = p.op2;
    id_write_reg_en_i   = p.we;
    id_write_reg_addr_i = p.waddr;
  endtask

  task automatic compare_all();
    bit exp_v;
    exp_v = (held.size() != 0);
    check_eq("ex_valid", 64'(ex_valid_o), 64'(exp_v));
    check_eq("id_ready", 64'(id_ready_o), 64'(m_ready()));
    check_eq("stall_cnt", 64'(stall_cnt_o), 64'(m_cnt));
    if (exp_v) begin
      check_eq("ex_sel", 64'(ex_alu_sel_o), 64'(held[0].sel));
      check_eq("ex_op", 64'(ex_alu_op_o), 64'(held[0].op));
      check_eq("ex_op1", 64'(ex_op_number_1_o), 64'(held[0].op1));
      check_eq("ex_op2", 64'(ex_op_number_2_o), 64'(held[0].op2));
      check_eq("ex_we", 64'(ex_write_reg_en_o), 64'(held[0].we));
      check_eq("ex_waddr", 64'(ex_write_reg_addr_o), 64'(held[0].waddr));
    end else begin
      check_eq("bubble_we", 64'(ex_write_reg_en_o), 64'd0);
      if (m_zero) begin
        check_eq("bubble_zero", 64'(|{ex_alu_sel_o, ex_alu_op_o, ex_op_number_1_o,
                                      ex_op_number_2_o, ex_write_reg_addr_o}), 64'd0);
      end
    end
    if (watch_dead && ex_valid_o && ex_op_number_1_o == 32'hDEAD) seen_dead = 1'b1;
  endtask

  // One clock: check current outputs, then advance the model across the edge
  task automatic tick();
    bit acc, del, stall, fl;
    id_ex_payload_t b;
    #1;
    compare_all();
    acc   = id_valid_i && m_ready();
    del   = (held.size() != 0) && ex_ready_i;
    stall = (held.size() != 0) && !ex_ready_i;
    fl    = flush_i;
    b     = '{sel: id_alu_sel_i, op: id_alu_op_i, op1: id_op_number_1_i,
              op2: id_op_number_2_i, we: id_write_reg_en_i, waddr: id_write_reg_addr_i};
    @(posedge clk);
    if (stall && m_cnt < CNT_MAX) m_cnt++;
    if (fl) begin
      held.delete();
      m_zero = 1'b1;
    end else begin
      if (del) void'(held.pop_front());
      if (acc) begin
        held.push_back(b);
        m_zero = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, PAYLOAD_ZERO);
    rst_n = 1'b0;
    #2;
    check_eq("rst_valid", 64'(ex_valid_o), 64'd0);
    check_eq("rst_we", 64'(ex_write_reg_en_o), 64'd0);
    check_eq("rst_payload", 64'(|{ex_alu_sel_o, ex_alu_op_o, ex_op_number_1_o,
                                  ex_op_number_2_o, ex_write_reg_addr_o}), 64'd0);
    check_eq("rst_cnt", 64'(stall_cnt_o), 64'd0);
    held.delete();
    m_cnt  = 0;
    m_zero = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_ready_after", 64'(id_ready_o), 64'd1);
  endtask

  initial begin
    id_ex_payload_t p;
    int unsigned    nvalid;

    #3;
    do_reset();
    repeat (2) tick();

    // Streaming: 8 back-to-back beats, EX always ready
    nvalid = 0;
    for (int k = 1; k <= 8; k++) begin
      p = rand_beat();
      p.op1 = 32'(k);
      drive(1'b1, 1'b1, 1'b0, p);
      tick();
      if (ex_valid_o) nvalid++;
    end
    check_eq("stream_valids", 64'(nvalid), 64'd8);
    drive(1'b0, 1'b1, 1'b0, PAYLOAD_ZERO);
    repeat (2) tick();

    // Reset while a beat is presented
    drive(1'b1, 1'b0, 1'b0, rand_beat());
    tick();
    check_eq("pre_reset_valid", 64'(ex_valid_o), 64'd1);
    do_reset();
    tick();

    // Stall: one accepted beat then three back-pressured cycles
    drive(1'b1, 1'b1, 1'b0, rand_beat());
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b0, rand_beat());
      tick();
    end
    check_eq("stall_cnt3", 64'(stall_cnt_o), 64'd3);
    check_eq("stall_ready", 64'(id_ready_o), 64'd0);
    drive(1'b0, 1'b1, 1'b0, PAYLOAD_ZERO);
    repeat (4) tick();

    // Flush with a same-cycle accept of 0xDEAD
    drive(1'b1, 1'b1, 1'b0, rand_beat());
    tick();
    p = rand_beat();
    p.op1 = 32'hDEAD;
    p.we  = 1'b1;
    watch_dead = 1'b1;
    drive(1'b1, 1'b1, 1'b1, p);
    tick();
    check_eq("flush_valid", 64'(ex_valid_o), 64'd0);
    check_eq("flush_we", 64'(ex_write_reg_en_o), 64'd0);
    drive(1'b0, 1'b1, 1'b0, PAYLOAD_ZERO);
    repeat (3) tick();
    check_eq("no_dead", 64'(seen_dead), 64'd0);
    watch_dead = 1'b0;

    // Saturation: 20 stalled cycles on a 4-bit counter
    do_reset();
    drive(1'b1, 1'b1, 1'b0, rand_beat());
    tick();
    drive(1'b0, 1'b0, 1'b0, PAYLOAD_ZERO);
    repeat (20) tick();
    check_eq("stall_sat", 64'(stall_cnt_o), 64'(CNT_MAX));
    drive(1'b0, 1'b1, 1'b0, PAYLOAD_ZERO);
    repeat (2) tick();
    check_eq("sat_hold", 64'(stall_cnt_o), 64'(CNT_MAX));

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      drive(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 32) == 0, rand_beat());
      tick();
    end
    drive(1'b0, 1'b1, 1'b0, PAYLOAD_ZERO);
    repeat (4) tick();
    check_eq("drained", 64'(ex_valid_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
